// File: rtl/uart_rx_fifo_if.sv
// Receiver-side handshake and bus-controller read path of the UART receive FIFO.
// The FIFO itself takes the slave modport.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_ready;
  logic                  rx_ack;
  logic                  rd_en;
  logic                  clr_ovf;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  not_empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;

  modport slave (
    input  rx_data, rx_ready, rd_en, clr_ovf,
    output rx_ack, rd_data, not_empty, full, count, overflow
  );

  modport master (
    output rx_data, rx_ready, rd_en, clr_ovf,
    input  rx_ack, rd_data, not_empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures each ready byte once, acks the receiver, and
// queues it in a first-word fall-through circular FIFO for the bus controller.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input logic           clk,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACK      = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  ovf, ack;
  logic                  is_empty, is_full;
  logic                  capture, pop, push, drop;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == FULL_CNT);
  assign capture  = (state == IDLE) && bus.rx_ready;
  assign pop      = bus.rd_en && !is_empty;
  // A same-cycle pop frees the slot, so a capture while full is still accepted.
  assign push     = capture && (!is_full || pop);
  assign drop     = capture && is_full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ack   <= 1'b0;
    end else begin
      ack <= capture;
      case (state)
        IDLE:     if (bus.rx_ready) state <= ACK;
        ACK:      state <= WAIT_LOW;
        WAIT_LOW: if (!bus.rx_ready) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop)             ovf <= 1'b1;
      else if (bus.clr_ovf) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rx_data;
  end

  assign bus.rx_ack    = ack;
  assign bus.rd_data   = is_empty ? '0 : mem[rd_ptr];
  assign bus.not_empty = !is_empty;
  assign bus.full      = is_full;
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: reference queue model plus a fill table.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic reset;

  uart_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) u_if ();

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];
  bit m_ovf = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         exp_count;
    bit         exp_full;
    bit         exp_ovf;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string nm);
    chk({nm, "_count"}, 32'(u_if.count), 32'(sb.size()));
    chk({nm, "_full"}, 32'(u_if.full), 32'(sb.size() == 16));
    chk({nm, "_not_empty"}, 32'(u_if.not_empty), 32'(sb.size() != 0));
    chk({nm, "_ovf"}, 32'(u_if.overflow), 32'(m_ovf));
  endtask

  // One full receiver handshake, optionally with a pop and/or clr_ovf in the capture cycle.
  task automatic send(input logic [7:0] b, input bit with_pop, input bit with_clr);
    bit drop;
    u_if.rx_data  = b;
    u_if.rx_ready = 1'b1;
    u_if.rd_en    = with_pop;
    u_if.clr_ovf  = with_clr;
    if (with_pop && sb.size() != 0) begin
      chk("pop_with_push_data", 32'(u_if.rd_data), 32'(sb[0]));
      void'(sb.pop_front());
    end
    drop = (sb.size() >= 16);
    if (!drop) sb.push_back(b);
    if (drop) m_ovf = 1'b1;
    else if (with_clr) m_ovf = 1'b0;
    tick();
    u_if.rd_en   = 1'b0;
    u_if.clr_ovf = 1'b0;
    chk("ack_high", 32'(u_if.rx_ack), 32'd1);
    tick();
    chk("ack_low", 32'(u_if.rx_ack), 32'd0);
    u_if.rx_ready = 1'b0;
    tick();
  endtask

  task automatic pop_one(input string nm);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: model empty, nothing to pop", nm);
      return;
    end
    chk({nm, "_data"}, 32'(u_if.rd_data), 32'(sb[0]));
    void'(sb.pop_front());
    u_if.rd_en = 1'b1;
    tick();
    u_if.rd_en = 1'b0;
    chk({nm, "_count"}, 32'(u_if.count), 32'(sb.size()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    for (int i = 0; i < 16; i++)
      tbl[i] = '{data: 8'(i), exp_count: i + 1, exp_full: (i == 15), exp_ovf: 1'b0};
    tbl[16] = '{data: 8'hAA, exp_count: 16, exp_full: 1'b1, exp_ovf: 1'b1};

    reset = 1'b1;
    u_if.rx_data = '0; u_if.rx_ready = 1'b0; u_if.rd_en = 1'b0; u_if.clr_ovf = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_count", 32'(u_if.count), 32'd0);
    chk("rst_not_empty", 32'(u_if.not_empty), 32'd0);
    chk("rst_full", 32'(u_if.full), 32'd0);
    chk("rst_ovf", 32'(u_if.overflow), 32'd0);
    chk("rst_ack", 32'(u_if.rx_ack), 32'd0);
    chk("rst_rd_data", 32'(u_if.rd_data), 32'd0);

    // Level held high for 6 cycles must push and ack only once.
    u_if.rx_data = 8'h41; u_if.rx_ready = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      acks += int'(u_if.rx_ack);
    end
    u_if.rx_ready = 1'b0;
    tick(); tick();
    sb.push_back(8'h41);
    chk("hold_acks", 32'(acks), 32'd1);
    chk("hold_count", 32'(u_if.count), 32'd1);
    chk("hold_rd_data", 32'(u_if.rd_data), 32'h41);
    pop_one("hold_pop");
    chk("hold_not_empty", 32'(u_if.not_empty), 32'd0);

    // Fill to full, then one dropped byte.
    for (int i = 0; i < 17; i++) begin
      send(tbl[i].data, 1'b0, 1'b0);
      chk("fill_count", 32'(u_if.count), 32'(tbl[i].exp_count));
      chk("fill_full", 32'(u_if.full), 32'(tbl[i].exp_full));
      chk("fill_ovf", 32'(u_if.overflow), 32'(tbl[i].exp_ovf));
    end
    for (int i = 0; i < 16; i++) pop_one("drain");
    chk_status("drained");
    u_if.clr_ovf = 1'b1; m_ovf = 1'b0;
    tick();
    u_if.clr_ovf = 1'b0;
    chk("clr_ovf", 32'(u_if.overflow), 32'd0);

    // Full FIFO with pop in the capture cycle: accepted, no overflow.
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b0, 1'b0);
    send(8'h55, 1'b1, 1'b0);
    chk("full_pop_count", 32'(u_if.count), 32'd16);
    chk("full_pop_ovf", 32'(u_if.overflow), 32'd0);
    for (int i = 0; i < 16; i++) pop_one("full_pop_drain");
    chk_status("after_55");

    // Pointer wrap: 40 push/pop pairs.
    for (int i = 0; i < 40; i++) begin
      send(8'h80 + 8'(i), 1'b0, 1'b0);
      pop_one("wrap");
    end
    u_if.rd_en = 1'b1;
    tick();
    u_if.rd_en = 1'b0;
    chk_status("rd_empty");
    chk("rd_empty_data", 32'(u_if.rd_data), 32'd0);

    // Reset in the ACK state with 3 bytes stored.
    for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i), 1'b0, 1'b0);
    u_if.rx_data = 8'h77; u_if.rx_ready = 1'b1;
    tick();
    chk("pre_rst_ack", 32'(u_if.rx_ack), 32'd1);
    reset = 1'b1; u_if.rx_ready = 1'b0;
    tick();
    reset = 1'b0;
    sb.delete(); m_ovf = 1'b0;
    chk("mid_rst_count", 32'(u_if.count), 32'd0);
    chk("mid_rst_ack", 32'(u_if.rx_ack), 32'd0);
    chk("mid_rst_rd_data", 32'(u_if.rd_data), 32'd0);
    send(8'h99, 1'b0, 1'b0);
    pop_one("post_rst");

    // Drop coinciding with clr_ovf: set wins.
    for (int i = 0; i < 16; i++) send(8'hE0 + 8'(i), 1'b0, 1'b0);
    send(8'hEE, 1'b0, 1'b1);
    chk("clr_vs_drop_ovf", 32'(u_if.overflow), 32'd1);
    chk_status("clr_vs_drop");
    u_if.clr_ovf = 1'b1; m_ovf = 1'b0;
    tick();
    u_if.clr_ovf = 1'b0;
    chk("clr_after_drop", 32'(u_if.overflow), 32'd0);
    for (int i = 0; i < 16; i++) pop_one("final_drain");
    chk_status("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer between the UART receiver (byte plus ready flag) and the peripheral bus controller's UART read path. Captures each received byte once, acknowledges the receiver so it clears its ready flag, and stores the byte in a circular FIFO. The bus controller pops bytes on CPU reads and sees empty, full, fill-count and sticky-overflow status. Bytes arriving while the CPU is busy are kept rather than overwritten in the single receiver register.

Parameters:
DATA_WIDTH, 8, width of one stored byte
DEPTH_LOG2, 4, log2 of FIFO depth; the default gives 16 entries

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
rx_data  input  DATA_WIDTH  received byte from the UART receiver; stable while rx_ready is high
rx_ready  input  1  level flag from the receiver: a byte is available
rx_ack  output  1  one-cycle pulse telling the receiver to clear its ready flag
rd_en  input  1  pop strobe from the bus controller, one cycle per CPU read
clr_ovf  input  1  clears the sticky overflow flag
rd_data  output  DATA_WIDTH  byte at the FIFO head (first-word fall-through)
not_empty  output  1  FIFO holds at least one byte
full  output  1  FIFO holds 2^DEPTH_LOG2 bytes
count  output  DEPTH_LOG2+1  number of stored bytes, from 0 to 2^DEPTH_LOG2
overflow  output  1  sticky: at least one received byte was dropped

Behaviour:
- Reset (takes priority over every other input):
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - overflow = 0, rx_ack = 0, capture FSM = IDLE.
  - not_empty = 0, full = 0, rd_data = 0.
  - Storage array contents are not reset.
- Capture FSM, states IDLE, ACK, WAIT_LOW:
  - IDLE: if rx_ready = 1, then push rx_data this cycle (subject to the full rule below) and go to ACK.
  - ACK: rx_ack = 1 for exactly this cycle, then go to WAIT_LOW.
  - WAIT_LOW: stay until rx_ready = 0, then go to IDLE. This stops a level held high from pushing the same byte twice.
  - rx_ack is registered and is high only in the ACK state.
- Push (capture event in IDLE):
  - Write mem[wr_ptr] = rx_data, then wr_ptr = wr_ptr + 1, wrapping modulo 2^DEPTH_LOG2.
  - If full and no pop happens in the same cycle: discard the byte, leave wr_ptr unchanged, set overflow = 1. rx_ack is still issued, so the receiver is released.
- Pop (rd_en = 1 and not_empty = 1):
  - rd_ptr = rd_ptr + 1, wrapping.
  - rd_en while empty is ignored: no pointer change, no flag change.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - This is allowed when full: the pop frees the slot, the push is accepted, and overflow is not set.
  - When empty, the pop is ignored and the push is accepted, so count becomes 1.
- count update:
  - +1 on an accepted push alone.
  - -1 on a valid pop alone.
  - Unchanged otherwise.
- Derived flags: not_empty = (count != 0) and full = (count == 2^DEPTH_LOG2), both derived from the registered count.
- rd_data:
  - Equals mem[rd_ptr] whenever not_empty = 1, and 0 when empty.
  - Latency from push to visibility is 1 cycle: a byte pushed at edge N is on rd_data after edge N when the FIFO was empty.
- overflow:
  - Cleared by clr_ovf = 1.
  - If clr_ovf and a new drop happen in the same cycle, set wins and overflow stays 1.
- Pointer wrap: after 2^DEPTH_LOG2 pushes and pops, both pointers return to 0 with no data corruption.
- Reset asserted mid-handshake (state ACK or WAIT_LOW): the FSM returns to IDLE and all stored data is lost. If rx_ready is still high after reset releases, that byte is captured once more, which is the intended behaviour.

Test Plan:
- Reset, then idle 5 cycles -> count = 0, not_empty = 0, full = 0, overflow = 0, rx_ack = 0, rd_data = 0x00.
- rx_data = 0x41, rx_ready held high for 6 cycles, then low -> exactly one push, one rx_ack pulse, count = 1, rd_data = 0x41. Then rd_en pulse -> count = 0, not_empty = 0.
- Push 0x00..0x0F (16 handshakes) -> full = 1, count = 16. Push 0xAA -> rx_ack pulses, byte dropped, overflow = 1. Pop 16 times -> 0x00..0x0F in order, 0xAA never seen.
- With full = 1, pulse rd_en in the same cycle as the capture of 0x55 -> count stays 16, overflow stays 0. 0x55 comes out last after 16 pops.
- Repeat 40 push/pop pairs of incrementing bytes (wrapping the pointers twice) -> every read equals its write. rd_en while empty -> no change.
- Assert reset during the ACK state with 3 bytes stored -> count = 0, FSM = IDLE, rx_ack = 0 on the next cycle. Assert clr_ovf together with a drop -> overflow = 1.
